// File: rtl/mips_pkg.sv
// Shared definitions for the P5 pipelined MIPS core: reset/memory defaults,
// the canonical NOP encoding and the IF/ID pipeline register layout.
package mips_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam int          IM_WORDS_DEFAULT = 1024;
   localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

   // One IF/ID pipeline register entry as seen by the decode stage.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc8;
      logic        valid;
      logic        fetch_err;
   } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: reset > clear (bubble) > stall (hold) > load.
// A clear always wins over a stall so a squashed slot never lingers in decode.
module if_id_reg
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        srst,
   input  logic        stall,
   input  logic        clr,
   input  logic [31:0] pc_in,
   input  logic [31:0] instr_in,
   input  logic        fetch_err_in,
   output if_id_t      if_id
);

   if_id_t if_id_reg_q;
   if_id_t if_id_next;

   // Select the next IF/ID contents from clear / stall / load requests.
   always_comb begin
      if_id_next = if_id_reg_q;
      if (clr) begin
         if_id_next.instr     = INSTR_NOP;
         if_id_next.pc        = pc_in;
         if_id_next.pc8       = pc_in + 32'd8;
         if_id_next.valid     = 1'b0;
         if_id_next.fetch_err = 1'b0;
      end else if (!stall) begin
         if_id_next.instr     = instr_in;
         if_id_next.pc        = pc_in;
         if_id_next.pc8       = pc_in + 32'd8;
         if_id_next.valid     = 1'b1;
         if_id_next.fetch_err = fetch_err_in;
      end
   end

   // Register the entry; synchronous reset clears every field.
   always_ff @(posedge clk) begin
      if (srst) begin
         if_id_reg_q <= '0;
      end else begin
         if_id_reg_q <= if_id_next;
      end
   end

   assign if_id = if_id_reg_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address
// and captures the returned word into the IF/ID register.
// Optional build macro FETCH_RANGE_CHECK_EN: when defined, fetches outside the
// instruction memory window [RESET_PC, RESET_PC + 4*IM_WORDS) become flagged
// NOPs; otherwise the fetched word passes through and fetch_err_d stays 0.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          IM_WORDS = IM_WORDS_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        clr_d,
   output logic [31:0] pc_f,
   input  logic [31:0] instr_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
   output logic        valid_d,
   output logic        fetch_err_d
);

   // Window bounds carried at 33 bits so a window touching 2^32 cannot wrap.
   localparam logic [32:0] WINDOW_LO = {1'b0, RESET_PC};
   localparam logic [32:0] WINDOW_HI = WINDOW_LO + (33'(IM_WORDS) << 2);

   logic [31:0] pc_reg;
   logic [31:0] pc_next;
   logic [31:0] fetch_instr;
   logic        fetch_err;
   if_id_t      if_id;

   // Next-PC mux: a stall also swallows any redirect; the branch unit
   // reasserts it once the stall clears. Targets are forced word-aligned.
   always_comb begin
      pc_next = pc_reg + 32'd4;
      if (stall) begin
         pc_next = pc_reg;
      end else if (redirect) begin
         pc_next = {redirect_pc[31:2], 2'b00};
      end
   end

   // PC register with synchronous reset to the first fetch address.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg <= RESET_PC;
      end else begin
         pc_reg <= pc_next;
      end
   end

`ifdef FETCH_RANGE_CHECK_EN
   logic in_window;

   // Out-of-window fetches are turned into flagged NOPs.
   always_comb begin
      in_window   = ({1'b0, pc_reg} >= WINDOW_LO) && ({1'b0, pc_reg} < WINDOW_HI);
      fetch_instr = in_window ? instr_f : INSTR_NOP;
      fetch_err   = !in_window;
   end
`else
   logic unused_window_cfg;

   // Without range checking the fetched word is passed through untouched.
   always_comb begin
      fetch_instr = instr_f;
      fetch_err   = 1'b0;
   end

   assign unused_window_cfg = ^{WINDOW_LO, WINDOW_HI};
`endif

   logic unused_redirect_bits;
   assign unused_redirect_bits = ^redirect_pc[1:0];

   if_id_reg u_if_id_reg (
      .clk          (clk),
      .srst         (reset),
      .stall        (stall),
      .clr          (clr_d),
      .pc_in        (pc_reg),
      .instr_in     (fetch_instr),
      .fetch_err_in (fetch_err),
      .if_id        (if_id)
   );

   assign pc_f        = pc_reg;
   assign instr_d     = if_id.instr;
   assign pc_d        = if_id.pc;
   assign pc8_d       = if_id.pc8;
   assign valid_d     = if_id.valid;
   assign fetch_err_d = if_id.fetch_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. The instruction memory is modelled as
// instr_f = ~pc_f so every expected word below is hand-computable.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        clr_d;
   logic [31:0] pc_f;
   logic [31:0] instr_f;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc8_d;
   logic        valid_d;
   logic        fetch_err_d;

   int n_vec = 0;
   int n_err = 0;

   fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .clr_d       (clr_d),
      .pc_f        (pc_f),
      .instr_f     (instr_f),
      .instr_d     (instr_d),
      .pc_d        (pc_d),
      .pc8_d       (pc8_d),
      .valid_d     (valid_d),
      .fetch_err_d (fetch_err_d)
   );

   always #5 clk = ~clk;

   assign instr_f = ~pc_f;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("vec %0d %s observed %h expected %h", n_vec, tag, obs, exp);
   endtask

   // Out-of-window fetch results depend on the build.
`ifdef FETCH_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   initial begin
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; clr_d = 1'b0;
      tick(); tick();
      chk("rst_pc_f",    pc_f,         32'h0000_3000);
      chk("rst_instr_d", instr_d,      32'h0);
      chk("rst_pc_d",    pc_d,         32'h0);
      chk("rst_pc8_d",   pc8_d,        32'h0);
      chk("rst_valid",   {31'b0, valid_d},     32'h0);
      chk("rst_err",     {31'b0, fetch_err_d}, 32'h0);

      // Free-running fetch.
      reset = 1'b0;
      tick();
      chk("run0_pc_f",   pc_f,    32'h0000_3004);
      chk("run0_pc_d",   pc_d,    32'h0000_3000);
      chk("run0_pc8_d",  pc8_d,   32'h0000_3008);
      chk("run0_instr",  instr_d, 32'hFFFF_CFFF);
      chk("run0_valid",  {31'b0, valid_d}, 32'h1);
      tick();
      chk("run1_pc_f",   pc_f,    32'h0000_3008);
      chk("run1_pc_d",   pc_d,    32'h0000_3004);

      // Stall for two cycles at 0x3008.
      stall = 1'b1;
      tick();
      chk("stl0_pc_f",   pc_f,    32'h0000_3008);
      chk("stl0_instr",  instr_d, 32'hFFFF_CFFB);
      tick();
      chk("stl1_pc_f",   pc_f,    32'h0000_3008);
      chk("stl1_instr",  instr_d, 32'hFFFF_CFFB);
      stall = 1'b0;
      tick();
      chk("rel_pc_f",    pc_f,    32'h0000_300C);
      chk("rel_instr",   instr_d, 32'hFFFF_CFF7);
      tick();
      chk("pre_br_pc_f", pc_f,    32'h0000_3010);

      // Redirect with a misaligned target: low bits dropped, delay slot kept.
      redirect = 1'b1; redirect_pc = 32'h0000_3103;
      tick();
      redirect = 1'b0;
      chk("br_pc_f",     pc_f,    32'h0000_3100);
      chk("br_slot",     instr_d, 32'hFFFF_CFEF);
      chk("br_slot_pc8", pc8_d,   32'h0000_3018);
      tick();
      chk("br_tgt_instr", instr_d, 32'hFFFF_CEFF);
      chk("br_tgt_pc_d",  pc_d,    32'h0000_3100);

      // Move to 0x3020, then stall + redirect + clr together.
      redirect = 1'b1; redirect_pc = 32'h0000_3020;
      tick();
      redirect = 1'b0;
      chk("go3020_pc_f", pc_f, 32'h0000_3020);
      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3400; clr_d = 1'b1;
      tick();
      stall = 1'b0; redirect = 1'b0; clr_d = 1'b0;
      chk("all_pc_f",    pc_f,    32'h0000_3020);
      chk("all_instr",   instr_d, 32'h0);
      chk("all_valid",   {31'b0, valid_d}, 32'h0);
      chk("all_pc_d",    pc_d,    32'h0000_3020);
      chk("all_pc8_d",   pc8_d,   32'h0000_3028);
      tick();
      chk("aft_pc_f",    pc_f,    32'h0000_3024);
      chk("aft_instr",   instr_d, 32'hFFFF_CFDF);
      chk("aft_valid",   {31'b0, valid_d}, 32'h1);

      // PC wrap at the top of the address space.
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      chk("wrap0_pc_f",  pc_f, 32'hFFFF_FFFC);
      tick();
      chk("wrap1_pc_f",  pc_f,  32'h0000_0000);
      chk("wrap1_pc_d",  pc_d,  32'hFFFF_FFFC);
      chk("wrap1_pc8_d", pc8_d, 32'h0000_0004);
      chk("wrap1_instr", instr_d, RC ? 32'h0 : 32'h0000_0003);
      chk("wrap1_err",   {31'b0, fetch_err_d}, RC ? 32'h1 : 32'h0);

      // First address past the window.
      redirect = 1'b1; redirect_pc = 32'h0000_4000;
      tick();
      redirect = 1'b0;
      chk("oow0_pc_f",   pc_f, 32'h0000_4000);
      tick();
      chk("oow_pc_d",    pc_d, 32'h0000_4000);
      chk("oow_instr",   instr_d, RC ? 32'h0 : 32'hFFFF_BFFF);
      chk("oow_valid",   {31'b0, valid_d}, 32'h1);
      chk("oow_err",     {31'b0, fetch_err_d}, RC ? 32'h1 : 32'h0);

      // Last word inside the window clears the error flag.
      redirect = 1'b1; redirect_pc = 32'h0000_3FFC;
      tick();
      redirect = 1'b0;
      tick();
      chk("inw_pc_d",    pc_d,    32'h0000_3FFC);
      chk("inw_instr",   instr_d, 32'hFFFF_C003);
      chk("inw_err",     {31'b0, fetch_err_d}, 32'h0);

      // Redirect back to the base.
      redirect = 1'b1; redirect_pc = 32'h0000_3000;
      tick();
      redirect = 1'b0;
      tick();
      chk("base_pc_d",   pc_d,    32'h0000_3000);
      chk("base_err",    {31'b0, fetch_err_d}, 32'h0);

      // Reset mid-redirect and mid-stall.
      redirect = 1'b1; redirect_pc = 32'h0000_3500; stall = 1'b1; reset = 1'b1;
      tick();
      redirect = 1'b0; stall = 1'b0;
      chk("rst2_pc_f",   pc_f,    32'h0000_3000);
      chk("rst2_instr",  instr_d, 32'h0);
      chk("rst2_pc_d",   pc_d,    32'h0);
      chk("rst2_valid",  {31'b0, valid_d}, 32'h0);
      reset = 1'b0;
      tick();
      chk("rst2_run_pc_f", pc_f, 32'h0000_3004);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
